// File: rtl/seg_frame_decoder.sv
// seg_frame_decoder: debounces a 56-bit eight-digit 7-segment bus, then
// decodes a stable snapshot one digit per cycle into hex nibbles and flags.
// Ports:
//   clk, rst (async, active-low), segs[55:0], out_ready
//   digits[31:0], blank_mask[7:0], err_mask[7:0], frame_valid, overrun
module seg_frame_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [55:0] segs,
   input  logic        out_ready,
   output logic [31:0] digits,
   output logic [7:0]  blank_mask,
   output logic [7:0]  err_mask,
   output logic        frame_valid,
   output logic        overrun
);

   typedef enum logic [1:0] {SETTLE, SCAN, VALID} state_t;

   localparam logic [3:0] LP_STABLE = 4'(STABLE_CYCLES);

   state_t      r_state;
   state_t      w_next;
   logic [55:0] r_s_q;
   logic [55:0] r_snap;
   logic [55:0] r_last;
   logic [3:0]  r_cnt;
   logic [2:0]  r_idx;
   logic        r_none;
   logic [31:0] r_sh_dig;
   logic [7:0]  r_sh_blank;
   logic [7:0]  r_sh_err;
   logic [31:0] r_digits;
   logic [7:0]  r_blank;
   logic [7:0]  r_err;
   logic        r_ovr;

   logic        w_stable;
   logic        w_new;
   logic        w_start;
   logic [6:0]  w_raw;
   logic [6:0]  w_pat;
   logic [3:0]  w_nib;
   logic        w_blank;
   logic        w_err;

   assign w_stable = (r_cnt == LP_STABLE);
   // Until the first accepted frame, any stable pattern is new.
   assign w_new    = r_none || (r_s_q != r_last);
   assign w_start  = w_stable && w_new;
   assign w_raw    = r_snap[r_idx*7 +: 7];
   assign w_pat    = ACTIVE_LOW ? ~w_raw : w_raw;

   always_comb begin
      w_nib   = 4'h0;
      w_blank = 1'b0;
      w_err   = 1'b0;
      case (w_pat)
         7'h3F:   w_nib = 4'h0;
         7'h06:   w_nib = 4'h1;
         7'h5B:   w_nib = 4'h2;
         7'h4F:   w_nib = 4'h3;
         7'h66:   w_nib = 4'h4;
         7'h6D:   w_nib = 4'h5;
         7'h7D:   w_nib = 4'h6;
         7'h07:   w_nib = 4'h7;
         7'h7F:   w_nib = 4'h8;
         7'h6F:   w_nib = 4'h9;
         7'h77:   w_nib = 4'hA;
         7'h7C:   w_nib = 4'hB;
         7'h39:   w_nib = 4'hC;
         7'h5E:   w_nib = 4'hD;
         7'h79:   w_nib = 4'hE;
         7'h71:   w_nib = 4'hF;
         7'h00:   w_blank = 1'b1;
         default: w_err = 1'b1;
      endcase
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         SETTLE:  if (w_start) w_next = SCAN;
         SCAN:    if (r_idx == 3'd7) w_next = VALID;
         VALID:   if (out_ready) w_next = SETTLE;
         default: w_next = SETTLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= SETTLE;
      else      r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s_q      <= '0;
         r_snap     <= '0;
         r_last     <= '0;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_none     <= 1'b1;
         r_sh_dig   <= '0;
         r_sh_blank <= '0;
         r_sh_err   <= '0;
         r_digits   <= '0;
         r_blank    <= '0;
         r_err      <= '0;
         r_ovr      <= 1'b0;
      end else begin
         r_s_q <= segs;
         if (segs != r_s_q)  r_cnt <= '0;
         else if (!w_stable) r_cnt <= r_cnt + 4'd1;
         unique case (r_state)
            SETTLE: begin
               if (w_start) begin
                  r_snap <= r_s_q;
                  r_idx  <= '0;
               end
            end
            SCAN: begin
               r_sh_dig[r_idx*4 +: 4] <= w_nib;
               r_sh_blank[r_idx]      <= w_blank;
               r_sh_err[r_idx]        <= w_err;
               r_idx                  <= r_idx + 3'd1;
               // Digit 7 bypasses its shadow so all outputs change together.
               if (r_idx == 3'd7) begin
                  r_digits <= {w_nib, r_sh_dig[27:0]};
                  r_blank  <= {w_blank, r_sh_blank[6:0]};
                  r_err    <= {w_err, r_sh_err[6:0]};
               end
            end
            VALID: begin
               if (w_stable && (r_s_q != r_snap)) r_ovr <= 1'b1;
               if (out_ready) begin
                  r_last <= r_snap;
                  r_none <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign digits      = r_digits;
   assign blank_mask  = r_blank;
   assign err_mask    = r_err;
   assign frame_valid = (r_state == VALID);
   assign overrun     = r_ovr;

endmodule

// File: tb/tb_seg_frame_decoder.sv
// tb_seg_frame_decoder: vector table plus scoreboard for seg_frame_decoder,
// with hand sequences for glitch, overrun and mid-scan reset.
module tb_seg_frame_decoder;

   typedef struct {
      logic [55:0] segs;
      logic        rdy;
      logic [31:0] dig;
      logic [7:0]  blk;
      logic [7:0]  err;
   } vec_t;

   typedef struct {
      logic [31:0] dig;
      logic [7:0]  blk;
      logic [7:0]  err;
   } exp_t;

   localparam logic [6:0] B = 7'h7F;

   logic        clk;
   logic        rst;
   logic [55:0] segs;
   logic        out_ready;
   logic [31:0] digits;
   logic [7:0]  blank_mask;
   logic [7:0]  err_mask;
   logic        frame_valid;
   logic        overrun;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sbq[$];
   vec_t tbl[6];
   logic pv = 1'b0;

   seg_frame_decoder #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk),
      .rst(rst),
      .segs(segs),
      .out_ready(out_ready),
      .digits(digits),
      .blank_mask(blank_mask),
      .err_mask(err_mask),
      .frame_valid(frame_valid),
      .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [55:0] mk(input logic [6:0] d7, d6, d5, d4,
                                      input logic [6:0] d3, d2, d1, d0);
      return {d7, d6, d5, d4, d3, d2, d1, d0};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input vec_t v);
      exp_t e;
      e.dig = v.dig;
      e.blk = v.blk;
      e.err = v.err;
      sbq.push_back(e);
   endtask

   task automatic wait_frame(input int bound, output int lat);
      lat = -1;
      for (int k = 1; k <= bound; k++) begin
         @(posedge clk);
         #1;
         if (frame_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   // Scoreboard: each new presentation is compared with the oldest entry.
   always @(negedge clk) begin
      if (!rst) begin
         pv = 1'b0;
      end else begin
         if (frame_valid && !pv) begin
            if (sbq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_frame: got digits %0h expected none",
                        digits);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("sb_digits", 64'(digits), 64'(e.dig));
               chk("sb_blank", 64'(blank_mask), 64'(e.blk));
               chk("sb_err", 64'(err_mask), 64'(e.err));
            end
         end
         pv = frame_valid;
      end
   end

   initial begin
      int lat;
      int lat2;
      int nfv;

      tbl[0] = '{mk(B, B, B, B, B, B, B, B), 1'b1,
                 32'h0000_0000, 8'hFF, 8'h00};
      tbl[1] = '{mk(B, B, B, B, B, B, 7'h40, 7'h78), 1'b0,
                 32'h0000_0007, 8'hFC, 8'h00};
      tbl[2] = '{mk(B, B, 7'h7E, B, 7'h00, B, B, B), 1'b1,
                 32'h0000_8000, 8'hD7, 8'h20};
      tbl[3] = '{mk(7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78),
                 1'b0, 32'h0123_4567, 8'h00, 8'h00};
      tbl[4] = '{mk(7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E),
                 1'b1, 32'h89AB_CDEF, 8'h00, 8'h00};
      tbl[5] = '{mk(7'h55, 7'h0E, B, B, B, B, B, B), 1'b1,
                 32'h0F00_0000, 8'h3F, 8'h80};

      rst       = 1'b0;
      segs      = tbl[0].segs;
      out_ready = 1'b1;
      #3;
      chk("rst_digits", 64'(digits), 64'h0);
      chk("rst_blank", 64'(blank_mask), 64'h0);
      chk("rst_err", 64'(err_mask), 64'h0);
      chk("rst_valid", 64'(frame_valid), 64'h0);
      chk("rst_overrun", 64'(overrun), 64'h0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         segs      = tbl[i].segs;
         out_ready = tbl[i].rdy;
         push(tbl[i]);
         wait_frame(40, lat);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd14);
         if (tbl[i].rdy) begin
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_one_cycle", i), 64'(frame_valid), 64'h0);
         end else begin
            repeat (5) @(posedge clk);
            #1;
            chk($sformatf("vec%0d_held", i), 64'(frame_valid), 64'h1);
            chk($sformatf("vec%0d_hold_dig", i), 64'(digits),
                64'(tbl[i].dig));
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_drop", i), 64'(frame_valid), 64'h0);
            @(negedge clk);
            out_ready = 1'b0;
         end
      end

      // Short glitches away from the accepted frame must not present.
      out_ready = 1'b1;
      for (int len = 3; len <= 4; len++) begin
         @(negedge clk);
         segs = tbl[3].segs;
         repeat (len) @(negedge clk);
         segs = tbl[5].segs;
         nfv = 0;
         repeat (50) begin
            @(posedge clk);
            #1;
            if (frame_valid) nfv++;
         end
         chk($sformatf("glitch%0d_no_frame", len), 64'(nfv), 64'h0);
      end
      chk("overrun_clear", 64'(overrun), 64'h0);

      // Overrun: new stable pattern while a frame waits for the consumer.
      @(negedge clk);
      segs      = tbl[4].segs;
      out_ready = 1'b0;
      push(tbl[4]);
      wait_frame(40, lat);
      chk("ovr_latency", 64'(lat), 64'd14);
      @(negedge clk);
      segs = tbl[1].segs;
      push(tbl[1]);
      repeat (6) @(posedge clk);
      #1;
      chk("ovr_set", 64'(overrun), 64'h1);
      chk("ovr_still_valid", 64'(frame_valid), 64'h1);
      chk("ovr_hold_dig", 64'(digits), 64'h89AB_CDEF);
      repeat (10) @(posedge clk);
      #1;
      chk("ovr_sticky", 64'(overrun), 64'h1);
      @(negedge clk);
      out_ready = 1'b1;
      wait_frame(40, lat);
      chk("ovr_redetect_lat", 64'(lat), 64'd10);
      @(posedge clk);
      #1;
      chk("ovr_redetect_drop", 64'(frame_valid), 64'h0);
      chk("ovr_sticky2", 64'(overrun), 64'h1);

      // Glitch of exactly STABLE_CYCLES+1 samples is a real frame.
      @(negedge clk);
      segs = tbl[3].segs;
      push(tbl[3]);
      push(tbl[5]);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (k == 5) segs = tbl[5].segs;
         if (frame_valid) begin
            lat = k;
            break;
         end
      end
      chk("glitch5_latency", 64'(lat), 64'd14);
      wait_frame(40, lat2);
      chk("glitch5_restore_lat", 64'(lat2), 64'd10);

      // Reset in the middle of a scan.
      @(negedge clk);
      segs = tbl[2].segs;
      repeat (8) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("scan_rst_digits", 64'(digits), 64'h0);
      chk("scan_rst_blank", 64'(blank_mask), 64'h0);
      chk("scan_rst_err", 64'(err_mask), 64'h0);
      chk("scan_rst_valid", 64'(frame_valid), 64'h0);
      chk("scan_rst_overrun", 64'(overrun), 64'h0);
      @(negedge clk);
      rst = 1'b1;
      push(tbl[2]);
      wait_frame(40, lat);
      chk("post_rst_latency", 64'(lat), 64'd14);
      @(posedge clk);
      #1;
      chk("post_rst_drop", 64'(frame_valid), 64'h0);
      chk("post_rst_overrun", 64'(overrun), 64'h0);
      repeat (20) @(posedge clk);
      #1;
      chk("sb_drained", 64'(sbq.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_frame_decoder.md
SEG_FRAME_DECODER -- requirements
Module: seg_frame_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical samples required before a frame is decoded; legal range 1..15.
REQ-002 SHALL have parameter ACTIVE_LOW, default 1: 1 means a segment is lit when its bit is 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port segs, input, 56 bits: eight 7-segment digits; digit k is segs[7k+6:7k] in bit order a(bit0)..g(bit6); digit 0 is rightmost.
REQ-006 SHALL have port out_ready, input, 1 bit: consumer accepts the presented frame.
REQ-007 SHALL have port digits, output, 32 bits: decoded hex value of digit k at digits[4k+3:4k].
REQ-008 SHALL have port blank_mask, output, 8 bits: bit k set when digit k is fully unlit.
REQ-009 SHALL have port err_mask, output, 8 bits: bit k set when digit k is neither blank nor a legal hex glyph.
REQ-010 SHALL have port frame_valid, output, 1 bit: frame presented (valid/ready handshake).
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag, set when a new stable frame is lost.

Function
REQ-012 SHALL register segs every cycle into s_q.
REQ-013 SHALL clear the stability counter when segs != s_q, else increment it, saturating at STABLE_CYCLES.
REQ-014 SHALL use FSM states SETTLE, SCAN and VALID.
REQ-015 SETTLE->SCAN SHALL occur when counter == STABLE_CYCLES and (s_q != last_frame or no frame has been accepted since reset); s_q SHALL be copied to a snapshot and digit index set to 0.
REQ-016 SCAN SHALL decode one snapshot digit per cycle, index 0..7, into shadow registers; segs changes during SCAN SHALL NOT affect the snapshot.
REQ-017 The edge that decodes digit 7 SHALL move to VALID and load digits, blank_mask and err_mask from the shadows atomically; outputs SHALL otherwise hold.
REQ-018 Decode SHALL first invert the digit when ACTIVE_LOW=1, then map gfedcba: 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=B, 39=C, 5E=D, 79=E, 71=F.
REQ-019 A decoded pattern of 00 SHALL set the blank bit; any other unlisted pattern SHALL set the err bit. Both cases SHALL put nibble 0.
REQ-020 frame_valid SHALL be 1 exactly while in VALID.
REQ-021 In VALID, a rising edge with out_ready=1 SHALL complete the transfer: last_frame <= snapshot, state -> SETTLE.
REQ-022 If out_ready is already 1 on entry to VALID, frame_valid SHALL be high for exactly one cycle.
REQ-023 out_ready outside VALID SHALL be ignored.
REQ-024 Latency: frame_valid SHALL rise STABLE_CYCLES+10 rising edges after the first edge that samples a new segs value that then stays constant (14 by default).
REQ-025 A segs glitch shorter than STABLE_CYCLES+1 cycles in SETTLE SHALL produce no frame.
REQ-026 A stable frame identical to last_frame SHALL NOT be re-presented.
REQ-027 In VALID, if counter == STABLE_CYCLES and s_q != snapshot, overrun SHALL set; the pending frame is discarded and re-detected after the transfer.

Reset
REQ-028 rst=0 SHALL immediately force: digits=0, blank_mask=0, err_mask=0, frame_valid=0, overrun=0, counter=0, state SETTLE, index 0, "no frame accepted" flag set, s_q/snapshot/last_frame=0.
REQ-029 Reset asserted during SCAN or VALID SHALL abort the frame; no partial outputs SHALL appear after release.

Verification
REQ-030 All digits 7'h7F (blank, ACTIVE_LOW=1), out_ready=1 from reset release -> frame_valid high 1 cycle at edge 14 after the first sample; blank_mask=FF, err_mask=00, digits=0.
REQ-031 Digit0=7'h78 ("7"), digit1=7'h40 ("0"), others 7'h7F, out_ready=0 -> digits=00000007, blank_mask=FC; frame_valid held until out_ready pulses, then drops the next cycle.
REQ-032 Digit3=7'h00 (all lit "8"), digit5=7'h7E (segment a only) -> digits[15:12]=8, err_mask=20, digits[23:20]=0.
REQ-033 Segs changed for 3 cycles then restored to the accepted frame -> no new frame_valid; the same frame held 50 cycles -> no re-presentation.
REQ-034 Frame held in VALID with out_ready=0 while a different segs stays stable 6 cycles -> overrun=1 and stays 1; after out_ready the new frame is presented.
REQ-035 rst pulsed low during SCAN -> all outputs 0 asynchronously; after release the held segs is decoded fresh with the REQ-024 latency.
